// File: rtl/fp_scale_pkg.sv
// Shared constants and request typedefs for the power-of-two float scaling scheduler.
// IEEE-754 single-precision field positions plus the per-request bundle {dir, num, shift}.
package fp_scale_pkg;

    localparam int          FP_EXP_MSB = 30;
    localparam int          FP_EXP_LSB = 23;
    localparam logic [7:0]  FP_EXP_MAX = 8'hFF;
    localparam int          FP_BIAS    = 127;
    localparam int          SHIFT_W    = 4;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } fp_dir_e;

    typedef struct packed {
        fp_dir_e              dir;
        logic [31:0]          num;
        logic [SHIFT_W-1:0]   shift;
    } fp_req_t;

endpackage

// File: rtl/fp_scale_core.sv
// Combinational power-of-two scaler: adds or subtracts k from the exponent field,
// saturating to inf / flushing to zero, and passing zero, denormal, inf and NaN through.
module fp_scale_core
    import fp_scale_pkg::*;
(
    input  fp_req_t      req_i,
    output logic [31:0]  num_o,
    output logic         ovf_o,
    output logic         unf_o
);

    logic [7:0] exp;
    logic [8:0] sum;
    logic [8:0] diff;

    // NOTE: every output gets a default first so no path through the branches infers a latch.
    always_comb begin
        exp   = req_i.num[FP_EXP_MSB:FP_EXP_LSB];
        sum   = {1'b0, exp} + {5'b0, req_i.shift};
        diff  = {1'b0, exp} - {5'b0, req_i.shift};
        num_o = req_i.num;
        ovf_o = 1'b0;
        unf_o = 1'b0;

        if (exp != 8'h00 && exp != FP_EXP_MAX && req_i.shift != '0) begin
            if (req_i.dir == DIR_LEFT) begin
                if (sum >= 9'd255) begin
                    num_o = {req_i.num[31], FP_EXP_MAX, 23'h0};
                    ovf_o = 1'b1;
                end else begin
                    num_o[FP_EXP_MSB:FP_EXP_LSB] = sum[7:0];
                end
            end else begin
                // diff is a 9-bit two's complement value; bit 8 set means e-k went negative.
                if (diff[8] || diff == 9'd0) begin
                    num_o = {req_i.num[31], 31'h0};
                    unf_o = 1'b1;
                end else begin
                    num_o[FP_EXP_MSB:FP_EXP_LSB] = diff[7:0];
                end
            end
        end
    end

endmodule

// File: rtl/fp_scale_scheduler.sv
// Round-robin scheduler sharing one fp_scale_core between N_REQ requesters,
// with a single registered output stage that honours downstream backpressure.
module fp_scale_scheduler
    import fp_scale_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic                  iClk,
    input  logic                  iRst,
    input  logic [N_REQ-1:0]      iReqValid,
    input  logic [N_REQ-1:0]      iReqDir,
    input  logic [32*N_REQ-1:0]   iReqNum,
    input  logic [4*N_REQ-1:0]    iReqShift,
    output logic [N_REQ-1:0]      oReqReady,
    output logic                  oValid,
    input  logic                  iReady,
    output logic [31:0]           oNum,
    output logic [ID_W-1:0]       oId,
    output logic                  oOvf,
    output logic                  oUnf
);

    fp_req_t           req [N_REQ];
    fp_req_t           sel_req;
    logic [31:0]       core_num;
    logic              core_ovf;
    logic              core_unf;

    logic              can_acc;
    logic              found;
    logic              transfer;
    logic [ID_W-1:0]   grant;
    int                cand;

    logic              valid_d, valid_q;
    logic [31:0]       num_d,   num_q;
    logic [ID_W-1:0]   id_d,    id_q;
    logic              ovf_d,   ovf_q;
    logic              unf_d,   unf_q;
    logic [ID_W-1:0]   ptr_d,   ptr_q;

    for (genvar r = 0; r < N_REQ; r++) begin : g_unpack
        assign req[r] = '{dir:   fp_dir_e'(iReqDir[r]),
                          num:   iReqNum[32*r +: 32],
                          shift: iReqShift[4*r +: 4]};
    end

    // Scan from the pointer upward, wrapping modulo N_REQ; the first valid requester wins.
    always_comb begin
        found = 1'b0;
        grant = '0;
        cand  = 0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = int'(ptr_q) + i;
            if (cand >= N_REQ) cand = cand - N_REQ;
            if (!found && iReqValid[ID_W'(cand)]) begin
                found = 1'b1;
                grant = ID_W'(cand);
            end
        end
    end

    assign can_acc   = !valid_q || iReady;
    assign transfer  = found && can_acc && !iRst;
    assign oReqReady = transfer ? ({{(N_REQ-1){1'b0}}, 1'b1} << grant) : '0;
    assign sel_req   = req[grant];

    fp_scale_core u_core (
        .req_i (sel_req),
        .num_o (core_num),
        .ovf_o (core_ovf),
        .unf_o (core_unf)
    );

    always_comb begin
        valid_d = valid_q;
        num_d   = num_q;
        id_d    = id_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        ptr_d   = ptr_q;
        if (transfer) begin
            valid_d = 1'b1;
            num_d   = core_num;
            id_d    = grant;
            ovf_d   = core_ovf;
            unf_d   = core_unf;
            ptr_d   = (grant == ID_W'(N_REQ-1)) ? '0 : grant + 1'b1;
        end else if (iReady) begin
            valid_d = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            valid_q <= 1'b0;
            num_q   <= '0;
            id_q    <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            ptr_q   <= '0;
        end else begin
            valid_q <= valid_d;
            num_q   <= num_d;
            id_q    <= id_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            ptr_q   <= ptr_d;
        end
    end

    assign oValid = valid_q;
    assign oNum   = num_q;
    assign oId    = id_q;
    assign oOvf   = ovf_q;
    assign oUnf   = unf_q;

endmodule
